// File: rtl/kb_char_fifo_if.sv
// kb_char_fifo_if: processor-side read handshake and status of the key character FIFO.
interface kb_char_fifo_if #(
    parameter int unsigned FIFO_AW = 3
);
    logic               rd_en;
    logic               clr_ovf;
    logic [7:0]         rd_data;
    logic               rd_valid;
    logic               empty;
    logic               full;
    logic [FIFO_AW:0]   count;
    logic               overflow;

    // Processor / I/O path side
    modport master (
        output rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full, count, overflow
    );

    // FIFO side
    modport slave (
        input  rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full, count, overflow
    );
endinterface

// File: rtl/kb_char_fifo.sv
// kb_char_fifo: synchronizes the PS/2 released-key scan code, detects new key
// events, translates scan set 2 to ASCII and queues characters for the processor.
// Build option: define KB_RAW_EN to bypass translation and queue raw scan codes.
module kb_char_fifo #(
    parameter int unsigned FIFO_AW    = 3,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  kb_char,
    kb_char_fifo_if.slave bus
);
    localparam int unsigned   CW        = FIFO_AW + 1;
    localparam logic [7:0]    IDLE_CODE = 8'hF0;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    logic [7:0]         s1_q, s2_q, s3_q;
    logic [7:0]         last_q, last_d;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
    logic               evt, mapped, push_req, push_ok, pop_ok;
    logic [7:0]         push_char;

    // Three-stage capture of the asynchronous code; S3 exists only for the stability compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= IDLE_CODE;
            s2_q <= IDLE_CODE;
            s3_q <= IDLE_CODE;
        end else begin
            s1_q <= kb_char;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

`ifdef KB_RAW_EN
    // Raw mode: every non-idle code is queued as-is
    always_comb begin
        push_char = s2_q;
        mapped    = (s2_q != IDLE_CODE);
    end
`else
    // Scan set 2 to ASCII; anything not listed is dropped
    always_comb begin
        mapped    = 1'b1;
        push_char = 8'h00;
        case (s2_q)
            8'h1C: push_char = 8'h61;  8'h32: push_char = 8'h62;
            8'h21: push_char = 8'h63;  8'h23: push_char = 8'h64;
            8'h24: push_char = 8'h65;  8'h2B: push_char = 8'h66;
            8'h34: push_char = 8'h67;  8'h33: push_char = 8'h68;
            8'h43: push_char = 8'h69;  8'h3B: push_char = 8'h6A;
            8'h42: push_char = 8'h6B;  8'h4B: push_char = 8'h6C;
            8'h3A: push_char = 8'h6D;  8'h31: push_char = 8'h6E;
            8'h44: push_char = 8'h6F;  8'h4D: push_char = 8'h70;
            8'h15: push_char = 8'h71;  8'h2D: push_char = 8'h72;
            8'h1B: push_char = 8'h73;  8'h2C: push_char = 8'h74;
            8'h3C: push_char = 8'h75;  8'h2A: push_char = 8'h76;
            8'h1D: push_char = 8'h77;  8'h22: push_char = 8'h78;
            8'h35: push_char = 8'h79;  8'h1A: push_char = 8'h7A;
            8'h45: push_char = 8'h30;  8'h16: push_char = 8'h31;
            8'h1E: push_char = 8'h32;  8'h26: push_char = 8'h33;
            8'h25: push_char = 8'h34;  8'h2E: push_char = 8'h35;
            8'h36: push_char = 8'h36;  8'h3D: push_char = 8'h37;
            8'h3E: push_char = 8'h38;  8'h46: push_char = 8'h39;
            8'h29: push_char = 8'h20;  8'h5A: push_char = 8'h0D;
            8'h66: push_char = 8'h08;
            default: mapped = 1'b0;
        endcase
    end
`endif

    // Next-state: event detect, push/pop arbitration, occupancy and sticky overflow
    always_comb begin
        last_d     = last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        ovf_d      = ovf_q;
        evt        = (s2_q == s3_q) && (s2_q != last_q);
        push_req   = evt && mapped;
        pop_ok     = bus.rd_en && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
        push_ok    = push_req && ((count_q != DEPTH_C) || pop_ok);
        rd_valid_d = pop_ok;
        if (evt) begin
            last_d = s2_q;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + FIFO_AW'(1);
            rd_data_d = mem[rd_ptr_q];
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= IDLE_CODE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage array; contents are meaningless once the pointers reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_char;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_kb_char_fifo.sv
// tb_kb_char_fifo: directed plus randomized checks against an event-level queue model.
module tb_kb_char_fifo;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] kb_char;

    kb_char_fifo_if #(.FIFO_AW(AW)) bus ();

    kb_char_fifo #(.FIFO_AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .kb_char (kb_char),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: character queue, last seen code, sticky overflow, last popped value
    byte unsigned q[$];
    logic [7:0]   m_last = 8'hF0;
    logic         m_ovf  = 1'b0;
    logic [7:0]   m_rd   = 8'h00;
    int           amap[int];

    function automatic int exp_char(logic [7:0] c);
`ifdef KB_RAW_EN
        return (c == 8'hF0) ? -1 : int'(c);
`else
        return amap.exists(int'(c)) ? amap[int'(c)] : -1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(string tag);
        check({tag, "_count"}, 32'(bus.count), 32'(q.size()));
        check({tag, "_empty"}, 32'(bus.empty), 32'(q.size() == 0));
        check({tag, "_full"},  32'(bus.full),  32'(q.size() == DEPTH));
        check({tag, "_ovf"},   32'(bus.overflow), 32'(m_ovf));
    endtask

    // Present a code and hold it; model applies the event at the key-event level
    task automatic apply_code(string tag, logic [7:0] c, int hold);
        int e;
        kb_char = c;
        repeat (hold) tick();
        if (c !== m_last) begin
            m_last = c;
            e = exp_char(c);
            if (e >= 0) begin
                if (q.size() < DEPTH) q.push_back(8'(e));
                else                  m_ovf = 1'b1;
            end
        end
        check_status(tag);
    endtask

    task automatic pop_one(string tag);
        logic exp_v;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        exp_v = (q.size() > 0);
        if (exp_v) m_rd = q.pop_front();
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'(exp_v));
        check({tag, "_data"},  32'(bus.rd_data),  32'(m_rd));
        tick();
        check({tag, "_pulse"}, 32'(bus.rd_valid), 32'(0));
        check_status(tag);
    endtask

    task automatic clr_ovf(string tag);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        m_ovf = 1'b0;
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(0));
    endtask

    task automatic model_reset();
        q.delete();
        m_last = 8'hF0;
        m_ovf  = 1'b0;
        m_rd   = 8'h00;
    endtask

    initial begin
        logic [7:0]  codes [36] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                                    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
        logic [7:0]  fill9 [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        logic [7:0]  pool [12] = '{8'h1C, 8'h24, 8'h4B, 8'h44, 8'h16, 8'h46, 8'h29, 8'h5A,
                                   8'h66, 8'hF0, 8'h76, 8'h1A};
        logic [7:0]  held;
        string       letters = "abcdefghijklmnopqrstuvwxyz0123456789";
        logic        exp_v;

        for (int i = 0; i < 36; i++) amap[int'(codes[i])] = int'(letters[i]);
        amap['h29] = 'h20;
        amap['h5A] = 'h0D;
        amap['h66] = 'h08;

        // 1: reset with idle code, idle code causes no push
        rst         = 1'b1;
        kb_char     = 8'hF0;
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(bus.rd_valid), 32'(0));
        check("rst_data",  32'(bus.rd_data),  32'(0));
        check_status("rst");
        rst = 1'b0;
        apply_code("idle", 8'hF0, 20);

        // 2: push latency of four edges, then one pop
        kb_char = 8'h1C;
        repeat (3) tick();
        check("lat_edge3_empty", 32'(bus.empty), 32'(1));
        tick();
        check("lat_edge4_empty", 32'(bus.empty), 32'(0));
        m_last = 8'h1C;
        q.push_back(8'(exp_char(8'h1C)));
        check_status("lat");
        pop_one("pop_a");

        // 3: "hello" with the repeated key suppressed
        apply_code("h", 8'h33, 10);
        apply_code("e", 8'h24, 10);
        apply_code("l1", 8'h4B, 10);
        apply_code("l2", 8'h4B, 10);
        apply_code("o", 8'h44, 10);
        for (int i = 0; i < 4; i++) pop_one("hello_pop");

        // 4: overflow on the ninth key, clear, drain, refill across the wrap
        for (int i = 0; i < 9; i++) apply_code("fill", fill9[i], 5);
        clr_ovf("clr");
        check_status("after_clr");
        for (int i = 0; i < 8; i++) pop_one("drain");
        apply_code("wrap_k", 8'h42, 5);
        apply_code("wrap_j", 8'h3B, 5);
        apply_code("wrap_m", 8'h3A, 5);
        for (int i = 0; i < 3; i++) pop_one("wrap_pop");

        // 5: full FIFO, event and pop on the same edge
        for (int i = 0; i < 8; i++) apply_code("refill", codes[26 + i], 5);
        kb_char = 8'h35;
        repeat (3) tick();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        m_rd = q.pop_front();
        m_last = 8'h35;
        q.push_back(8'(exp_char(8'h35)));
        check("simul_valid", 32'(bus.rd_valid), 32'(1));
        check("simul_data",  32'(bus.rd_data),  32'(m_rd));
        check_status("simul");
        for (int i = 0; i < 8; i++) pop_one("simul_drain");
        pop_one("empty_pop");

        // 6: unmapped code, then asynchronous reset with entries queued
        apply_code("unmapped", 8'h76, 6);
        while (q.size() > 0) pop_one("unmapped_pop");
        apply_code("pre_a", 8'h1C, 5);
        apply_code("pre_b", 8'h32, 5);
        apply_code("pre_c", 8'h21, 5);
        held = kb_char;
        #2;
        rst = 1'b1;
        #1;
        check("arst_empty", 32'(bus.empty), 32'(1));
        check("arst_count", 32'(bus.count), 32'(0));
        tick();
        rst = 1'b0;
        model_reset();
        apply_code("held_through_rst", held, 5);
        pop_one("held_pop");

        // Randomized mix of key events, pops and overflow clears
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: apply_code("rnd_key", pool[$urandom_range(0, 11)],
                                             int'($urandom_range(4, 7)));
                6, 7, 8:          pop_one("rnd_pop");
                default: begin
                    clr_ovf("rnd_clr");
                    check_status("rnd_clr");
                end
            endcase
        end
        exp_v = 1'b0;
        while (q.size() > 0 && !exp_v) begin
            pop_one("final_drain");
            if (checks > 5000) exp_v = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kb_char_fifo.md
Name: kb_char_fifo

Overview:
- Downstream consumer of the PS/2 keyboard receiver's 8-bit released-key scan code (scan set 2). That code changes asynchronously to the system clock.
- Moves the code into the system clock domain and detects each new key event.
- Translates the code to ASCII and queues the result in a small FIFO.
- The processor's I/O path drains the FIFO with a read-enable handshake.

Parameters:
- FIFO_AW, 3, FIFO address width.
- FIFO_DEPTH, 8, number of entries; must equal 2**FIFO_AW.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- KB_Char  in  8  released-key scan code from the PS/2 receiver; asynchronous to Clk; idles at 8'hF0.
- Rd_En  in  1  pop request from the processor; sampled on the rising edge of Clk.
- Rd_Data  out  8  popped character; registered.
- Rd_Valid  out  1  one-cycle pulse; Rd_Data is valid in this cycle.
- Empty  out  1  FIFO holds 0 entries.
- Full  out  1  FIFO holds FIFO_DEPTH entries.
- Count  out  FIFO_AW+1  current occupancy.
- Overflow  out  1  sticky; a character was dropped because the FIFO was full.
- Clr_Ovf  in  1  synchronous clear of Overflow.

Behaviour:
- Reset values, all asserted asynchronously:
  - Rd_Data=0, Rd_Valid=0, Empty=1, Full=0, Count=0, Overflow=0.
  - Both synchronizer stages, the stability register and Last_Code reset to 8'hF0.
  - Both FIFO pointers reset to 0.
- Synchronizer:
  - KB_Char passes through two flops (S1, S2), then a third register S3.
  - A code is considered stable when S2==S3. This rejects multi-bit skew.
- Event detection:
  - An event fires when S2==S3 and S2!=Last_Code.
  - On the event cycle, Last_Code<=S2.
  - Because detection works on value change, a repeated press of the same key is not seen until a different code arrives. This is a known limitation of the upstream interface.
  - A stable S2 of 8'hF0 updates Last_Code but pushes nothing.
- Translation (combinational from S2), scan set 2 to ASCII:
  - Letters map to lowercase: 1C→61 'a' … 1A→7A 'z', full set-2 letter map.
  - Digits: 45→30 … 46→39.
  - 29→20 (space), 5A→0D (enter), 66→08 (backspace).
  - Any unmapped code marks the event as dropped: nothing is pushed and Overflow is unaffected. Last_Code still updates.
- Push:
  - An event with a mapped code writes at the write pointer on the same edge.
  - Latency: Empty deasserts on the 4th rising edge of Clk after KB_Char settles (S1, S2, S3, push).
- Pop:
  - Rd_En while Empty=0 loads the head entry into Rd_Data and pulses Rd_Valid for 1 cycle on the next edge.
  - Rd_En while Empty=1 is ignored: Rd_Valid=0 and Rd_Data holds its value.
- Pointers:
  - Each pointer is FIFO_AW bits and wraps modulo FIFO_DEPTH.
  - Count tracks occupancy. Empty is Count==0; Full is Count==FIFO_DEPTH.
- Simultaneous push and pop:
  - When not empty: both occur and Count is unchanged.
  - When full: both succeed, since the pop frees the slot in the same cycle.
  - When empty: only the push occurs and the pop is ignored.
- Push while Full without a pop: the character is discarded and Overflow<=1.
  - Clr_Ovf clears Overflow.
  - Clr_Ovf and a new overflow in the same cycle: Overflow stays 1 (set wins).
- Reset mid-operation: all contents are discarded immediately. After release, the current KB_Char is re-synchronized against Last_Code=F0, so a non-F0 code that was held through reset pushes once.

Optional Feature:
- Macro: KB_RAW_EN.
- Defined: translation is bypassed. Every non-F0 stable change pushes the raw scan code, including codes that are unmapped in translated mode. No code is ever dropped as unmapped.
- Undefined: ASCII translation and unmapped-drop behave as described in Behaviour.

Test Plan:
1. Reset asserted with KB_Char=F0, then released → Empty=1, Count=0, Rd_Valid=0, Overflow=0. Holding KB_Char=F0 for 20 cycles causes no push.
2. KB_Char changes F0→1C → Empty=0 on edge 4. Pulse Rd_En → Rd_Valid=1 with Rd_Data=8'h61 for one cycle, then Empty=1.
3. Sequence 33,24,4B,4B,44 with each code held 10 cycles → the FIFO holds exactly 68,65,6C,6F ('h','e','l','o'); the duplicate 4B is not pushed. Four pops return the values in order.
4. Push 9 distinct mapped codes with no reads → Full=1, Count=8, Overflow=1, and the 9th code is lost. Pulse Clr_Ovf → Overflow=0. Eight pops return the first 8 characters in order, and pointers wrap correctly on a subsequent refill.
5. With the FIFO full, an event and Rd_En land in the same cycle → Count stays 8, Overflow=0, and the new character is the last one popped. A separate run: Rd_En with Empty=1 → no Rd_Valid and Rd_Data unchanged.
6. Unmapped code 76 → no push when translated; with KB_RAW_EN defined, 76 is pushed and read back as 8'h76. Reset asserted with 3 entries queued → Empty=1 and Count=0 immediately, without waiting for a clock edge.
